mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
Parametrised successor to the pipeline's MEMORY stage. Replaces the fixed word-only data memory with a load/store unit.
- Byte/half/word accesses with byte-lane write enables; loads are sign- or zero-extended.
- Misaligned-access detection.
- Configurable read latency, with a stall handshake back to the pipeline.
- Saturating access counters.
- Retains the testbench preload port.
Sits between EX/MEM and MEM/WB registers; the pipeline holds the request stable while stall=1.

Parameters:
ADDR_W, 14, word-address bits; memory depth = 2**ADDR_W 32-bit words
READ_LAT, 1, load latency in cycles from acceptance to rsp_valid; legal 1..7
CNT_W, 16, width of each saturating performance counter

Ports:
CLK  in  1  clock
RSTn  in  1  synchronous active-low reset
EN  in  1  global enable; 0 freezes FSM, latency counter, perf counters; suppresses writes
TB_LOAD_DATA_CTRL  in  1  testbench preload override
TB_LOAD_DATA_ADDR  in  ADDR_W  preload word address
TB_LOAD_DATA_DATA  in  32  preload word
req_valid  in  1  access request from EX/MEM
req_we  in  1  1=store, 0=load
req_size  in  2  mem_size_t: B/H/W
req_unsigned  in  1  1=zero-extend load (LBU/LHU)
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data, LSB-aligned
stall  out  1  pipeline hold request
rsp_valid  out  1  one-cycle load-data-valid pulse
rsp_rdata  out  32  extended load data
misalign  out  1  one-cycle misaligned-request pulse
load_cnt, store_cnt, misalign_cnt  out  CNT_W each  saturating counters

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous, active-low on RSTn.
- Reset values:
  - state=IDLE; stall=0, rsp_valid=0, rsp_rdata=0, misalign=0; all counters 0.
  - RAM contents are not reset.
- Address decode: word index = req_addr[ADDR_W+1:2], wraps modulo depth. Lane = req_addr[1:0].
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0.
  - No memory access, no stall.
  - misalign=1 in the following cycle; misalign_cnt++.
- Store (IDLE, req_valid, req_we, aligned):
  - Written at the same edge; no stall; store_cnt++.
  - B writes lane addr[1:0] with wdata[7:0]; H writes lanes {addr[1],0} and +1 with wdata[15:0]; W writes all lanes.
  - Unselected lanes are untouched.
- Load FSM (states IDLE, WAIT, RESP):
  - IDLE: on req_valid & !req_we & aligned, stall=1 combinationally in that cycle. At the edge: latch size/unsigned/lane, start RAM read, cnt=READ_LAT-1, load_cnt++. Next state is WAIT if READ_LAT>1, else RESP.
  - WAIT: stall=1; cnt decrements; enter RESP when cnt==1.
  - RESP: rsp_valid=1, stall=0, rsp_rdata valid. req_valid is ignored in RESP because it still shows the completed load. Next state IDLE.
  - Latency: rsp_valid asserts READ_LAT cycles after acceptance. Back-to-back loads take READ_LAT+1 cycles each.
- Extension: B selects byte[lane], H selects half[addr[1]]; sign-extend unless req_unsigned. W passes through.
- rsp_rdata holds its last value until the next RESP.
- stall = (IDLE & req_valid & !req_we & aligned) | WAIT.
- EN=0: state, counters, cnt and outputs hold; no RAM write; stall holds its current value.
- TB_LOAD_DATA_CTRL=1 has priority over everything:
  - Full-word write of TB data at TB address.
  - Requests ignored; stall=0.
  - Any in-flight load is aborted to IDLE without rsp_valid.
  - Counters do not increment.
- Counters saturate at 2**CNT_W-1.
- Reset asserted mid-load: IDLE at the next edge, no rsp_valid.
- Reset during TB preload: the preload write still occurs; reset does not gate the RAM.

Decomposition:
- Shared package my_pkg:
  - typedef enum logic[1:0] mem_size_t {MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10}
  - typedef enum lsu_state_t {LSU_IDLE, LSU_WAIT, LSU_RESP}
  - constant LSU_MAX_LAT=7
- Sub-module lsu_byte_ram (params ADDR_W, READ_LAT):
  - 2**ADDR_W x 32 array with 4 byte write-enables.
  - Read data registered through a READ_LAT-deep pipeline.
- Top level holds the FSM, lane/extension logic, misalignment check and counters.

Test Plan:
- Preload word 0x0000_001C <- 0x8081_F2F3 via TB port; LB 0x70 -> rsp_rdata 0xFFFF_FFF3; LBU 0x73 -> 0x0000_0080; LH 0x72 -> 0xFFFF_8081; LHU 0x70 -> 0x0000_F2F3.
- SB 0x71 wdata 0x55 onto word 0x1122_3344; LW 0x70 -> 0x1122_5544; store_cnt=1, no stall during store.
- READ_LAT=3: LW accepted cycle 0 -> stall=1 cycles 0-2, rsp_valid=1 exactly cycle 3 with stall=0; two back-to-back LWs -> second rsp_valid at cycle 7.
- LH 0x01 and LW 0x02 -> misalign pulses one cycle each; no stall, no rsp_valid, RAM unchanged; misalign_cnt=2.
- LW in WAIT then TB_LOAD_DATA_CTRL=1 (or RSTn=0) -> IDLE next edge, no rsp_valid, stall=0.
- CNT_W=2: issue 5 loads -> load_cnt saturates at 3; EN=0 during a load freezes stall, and rsp_valid is delayed by exactly the frozen cycles.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package my_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    localparam int unsigned LSU_MAX_LAT  = 7;
    localparam int unsigned LSU_CNT_BITS = 3;   // wide enough for LSU_MAX_LAT

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
        logic mis;
        case (size)
            MEM_B:   mis = 1'b0;
            MEM_H:   mis = lane[0];
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

    // Byte-lane enables for a store of the given size at the given lane.
    function automatic logic [3:0] lsu_store_be(input mem_size_t size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            MEM_B:   be = 4'(4'b0001 << lane);
            MEM_H:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate LSB-aligned store data onto every lane it could land in.
    function automatic logic [31:0] lsu_store_data(input mem_size_t size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            MEM_B:   d = {4{wdata[7:0]}};
            MEM_H:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Select the addressed byte/half from a RAM word and sign/zero-extend it.
    function automatic logic [31:0] lsu_extend(input mem_size_t size, input logic uns,
                                               input logic [1:0] lane, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_B:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            MEM_H:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_byte_ram.sv
// Word-organised data RAM with byte-lane writes and a READ_LAT-deep read pipeline.
module lsu_byte_ram #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem  [DEPTH];
    logic [31:0] pipe [READ_LAT];

    // Byte-lane write port; unselected lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read pipeline; advances only when the owning stage is enabled so data stays aligned with its FSM.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            pipe[0] <= mem[rd_addr];
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rd_data = pipe[READ_LAT-1];

endmodule

// File: rtl/mem_stage_lsu.sv
// MEMORY-stage load/store unit: sized accesses, misalignment detection, latency handshake, perf counters.
module mem_stage_lsu
    import my_pkg::*;
#(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              TB_LOAD_DATA_CTRL,
    input  logic [ADDR_W-1:0] TB_LOAD_DATA_ADDR,
    input  logic [31:0]       TB_LOAD_DATA_DATA,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt,
    output logic [CNT_W-1:0]  misalign_cnt
);

    logic [ADDR_W-1:0]       word_idx;
    logic [1:0]              lane;
    mem_size_t               req_sz;
    logic                    req_mis;
    logic                    adv;
    logic                    unused_addr;

    lsu_state_t              state_q, state_d;
    logic [LSU_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                    acc_load, acc_store, flag_mis, stall_c;

    mem_size_t               size_q;
    logic                    uns_q;
    logic [1:0]              lane_q;
    logic                    stall_q;
    logic                    misalign_q;
    logic [31:0]             rdata_q;
    logic [CNT_W-1:0]        load_q, store_q, mis_q;

    logic [3:0]              ram_be;
    logic [ADDR_W-1:0]       ram_waddr;
    logic [31:0]             ram_wdata, ram_rdata, ext_data;

    assign word_idx    = req_addr[ADDR_W+1:2];
    assign lane        = req_addr[1:0];
    assign req_sz      = mem_size_t'(req_size);
    assign req_mis     = is_misaligned(req_sz, lane);
    assign adv         = EN && !TB_LOAD_DATA_CTRL;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    // Next-state and request classification; requests are only taken in IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_load  = 1'b0;
        acc_store = 1'b0;
        flag_mis  = 1'b0;
        stall_c   = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (req_mis) begin
                        flag_mis = 1'b1;
                    end else if (req_we) begin
                        acc_store = 1'b1;
                    end else begin
                        acc_load = 1'b1;
                        stall_c  = 1'b1;
                        cnt_d    = LSU_CNT_BITS'(READ_LAT - 1);
                        state_d  = (READ_LAT > 1) ? LSU_WAIT : LSU_RESP;
                    end
                end
            end
            LSU_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - LSU_CNT_BITS'(1);
                if (cnt_q == LSU_CNT_BITS'(1)) begin
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // RAM write port: preload has priority, otherwise an accepted aligned store.
    always_comb begin
        ram_be    = 4'b0000;
        ram_waddr = word_idx;
        ram_wdata = lsu_store_data(req_sz, req_wdata);
        if (TB_LOAD_DATA_CTRL) begin
            ram_be    = 4'b1111;
            ram_waddr = TB_LOAD_DATA_ADDR;
            ram_wdata = TB_LOAD_DATA_DATA;
        end else if (RSTn && adv && acc_store) begin
            ram_be = lsu_store_be(req_sz, lane);
        end
    end

    // State, latched load attributes, response hold and saturating counters.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= LSU_IDLE;
            cnt_q      <= '0;
            stall_q    <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
            size_q     <= MEM_W;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            load_q     <= '0;
            store_q    <= '0;
            mis_q      <= '0;
        end else if (TB_LOAD_DATA_CTRL) begin
            state_q    <= LSU_IDLE;
            cnt_q      <= '0;
            stall_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (EN) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stall_q    <= stall_c;
            misalign_q <= flag_mis;
            if (acc_load) begin
                size_q <= req_sz;
                uns_q  <= req_unsigned;
                lane_q <= lane;
            end
            if (state_q == LSU_RESP) begin
                rdata_q <= ext_data;
            end
            if (acc_load && (load_q != '1)) begin
                load_q <= load_q + CNT_W'(1);
            end
            if (acc_store && (store_q != '1)) begin
                store_q <= store_q + CNT_W'(1);
            end
            if (flag_mis && (mis_q != '1)) begin
                mis_q <= mis_q + CNT_W'(1);
            end
        end
    end

    lsu_byte_ram #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) u_ram (
        .clk     (CLK),
        .wr_be   (ram_be),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (adv),
        .rd_addr (word_idx),
        .rd_data (ram_rdata)
    );

    assign ext_data     = lsu_extend(size_q, uns_q, lane_q, ram_rdata);
    assign stall        = TB_LOAD_DATA_CTRL ? 1'b0 : (EN ? stall_c : stall_q);
    assign rsp_valid    = (state_q == LSU_RESP) && !TB_LOAD_DATA_CTRL;
    assign rsp_rdata    = rsp_valid ? ext_data : rdata_q;
    assign misalign     = misalign_q;
    assign load_cnt     = load_q;
    assign store_cnt    = store_q;
    assign misalign_cnt = mis_q;

endmodule
